// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master sequencer and its environment:
// command opcodes, master FSM states, frame constants and the slave FSM
// state encoding used when reasoning about what the slave sees.
package spi_pkg;

  // Command opcodes carried in the top two bits of every frame.
  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } spi_op_e;

  // Master sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TURN  = 3'd3,
    ST_CAPT  = 3'd4,
    ST_GAP   = 3'd5
  } mst_state_e;

  // Frame geometry.
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned SEL_CYC    = 2;
  localparam int unsigned RX_BITS    = 8;

  // Slave FSM encoding, so checkers can name the state the slave reaches.
  localparam logic [2:0] SLV_IDLE      = 3'b000;
  localparam logic [2:0] SLV_CHK_CMD   = 3'b001;
  localparam logic [2:0] SLV_WRITE     = 3'b010;
  localparam logic [2:0] SLV_READ_ADD  = 3'b011;
  localparam logic [2:0] SLV_READ_DATA = 3'b100;

  // Down-counter load value for a phase lasting 'cycles' clocks.
  function automatic logic [3:0] cnt_load(input int unsigned cycles);
    return 4'(cycles - 32'd1);
  endfunction

endpackage

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: takes one 10-bit command per handshake, frames it
// on SS_n/MOSI, and for read-data commands captures the 8-bit MISO reply
// and returns it with a one-cycle response strobe.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned TA_CYC  = 2,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [3:0] SEL_LOAD   = cnt_load(SEL_CYC);
  localparam logic [3:0] SHIFT_LOAD = cnt_load(FRAME_BITS);
  localparam logic [3:0] TA_LOAD    = cnt_load(TA_CYC);
  localparam logic [3:0] CAPT_LOAD  = cnt_load(RX_BITS);
  localparam logic [3:0] GAP_LOAD   = cnt_load(GAP_CYC);

  mst_state_e            state_q, state_d;
  spi_op_e               op_q, op_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [RX_BITS-1:0]    rx_q, rx_d;
  logic [RX_BITS-1:0]    rsp_data_q, rsp_data_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  ss_n_q, ss_n_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;

  // Handshake ready straight from the state register, forced low in reset.
  assign cmd_ready = (state_q == ST_IDLE) && !rst;

  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Next-state logic; line outputs are computed for the state being entered
  // so the registered SS_n/MOSI line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    rx_d        = rx_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    mosi_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_SEL;
          cnt_d   = SEL_LOAD;
          shreg_d = {cmd_op, cmd_data};
          op_d    = spi_op_e'(cmd_op);
          mosi_d  = cmd_op[1];
        end else begin
          cnt_d = 4'd0;
        end
      end

      // Select bit is held for both SEL cycles and again as the first
      // SHIFT bit, so the slave's command check samples a stable level.
      ST_SEL: begin
        mosi_d = shreg_q[FRAME_BITS-1];
        if (cnt_q == 4'd0) begin
          state_d = ST_SHIFT;
          cnt_d   = SHIFT_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == 4'd0) begin
          if (op_q == OP_RD_DATA) begin
            state_d = ST_TURN;
            cnt_d   = TA_LOAD;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d   = cnt_q - 4'd1;
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          mosi_d  = shreg_q[FRAME_BITS-2];
        end
      end

      ST_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CAPT;
          cnt_d   = CAPT_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_CAPT: begin
        rx_d = {rx_q[RX_BITS-2:0], MISO};
        if (cnt_q == 4'd0) begin
          state_d     = ST_GAP;
          cnt_d       = GAP_LOAD;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q[RX_BITS-2:0], MISO};
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    ss_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered line outputs; reset raises SS_n at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WR_ADDR;
      cnt_q       <= 4'd0;
      shreg_q     <= '0;
      rx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl, built for two parameter sets
// (TA=2/GAP=1 and TA=1/GAP=3). A behavioural slave+RAM decodes the frames
// seen on SS_n/MOSI and answers on MISO; a reference RAM model updated at
// command issue predicts frames and read responses.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input int cfg, input bit ok, input string name,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cfg%0d %s: got 0x%0h expected 0x%0h", cfg, name, act, exp);
    end
  endtask

  function automatic logic [2:0] slv_expected(input logic [1:0] op);
    case (op)
      2'b00, 2'b01: return SLV_WRITE;
      2'b10:        return SLV_READ_ADD;
      default:      return SLV_READ_DATA;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int TA  = (g == 0) ? 2 : 1;
    localparam int GAP = (g == 0) ? 1 : 3;
    localparam int CFG = g;

    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready, rsp_valid, busy, ss_n, mosi;
    logic       miso = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] rsp_data;

    spi_master_ctrl #(.TA_CYC(TA), .GAP_CYC(GAP)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .busy(busy), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
    );

    // Reference model (updated when a command is accepted).
    logic [7:0] ref_mem [256];
    logic [7:0] ref_wr = 8'h00, ref_rd = 8'h00;
    // Behavioural slave (updated from decoded frames).
    logic [7:0] sl_mem [256];
    logic [7:0] sl_wr = 8'h00, sl_rd = 8'h00, sl_byte = 8'h00;

    logic [9:0] exp_frame_q [$];
    logic [7:0] exp_rsp_q [$];
    logic [7:0] last_rsp = 8'h00;
    logic [63:0] fbits = '0;
    logic [9:0] ef, got;
    logic [7:0] er;
    logic [2:0] seen_st;
    int  fc = 0, hi_cnt = 0, gap_cnt = 0, exp_len = 0, bi = 0;
    bit  had_frame = 1'b0, gap_trk = 1'b0, prev_rv = 1'b0, rd_frame = 1'b0;
    bit  done_flag = 1'b0;

    task automatic model(input logic [1:0] op, input logic [7:0] data);
      case (op)
        2'b00:   ref_wr = data;
        2'b01:   ref_mem[ref_wr] = data;
        2'b10:   ref_rd = data;
        default: exp_rsp_q.push_back(ref_mem[ref_rd]);
      endcase
      exp_frame_q.push_back({op, data});
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [1:0] op, input logic [7:0] data, input bit hold);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      while (cmd_ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk(CFG, cmd_ready === 1'b1, "accept_timeout", n, 0);
      if (cmd_ready === 1'b1) begin
        model(op, data);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        chk(CFG, busy === 1'b1 && ss_n === 1'b0, "frame_start", int'({busy, ss_n}), 2);
      end else begin
        cmd_valid = 1'b0;
      end
    endtask

    task automatic drain();
      int n = 0;
      while ((exp_frame_q.size() != 0 || exp_rsp_q.size() != 0 || busy !== 1'b0) && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk(CFG, exp_frame_q.size() == 0, "drain_frames", exp_frame_q.size(), 0);
      chk(CFG, exp_rsp_q.size() == 0, "drain_rsp", exp_rsp_q.size(), 0);
    endtask

    // Stimulus.
    initial begin
      logic [1:0] op;
      logic [7:0] data;
      bit hold;
      ref_mem = '{default: 8'h00};
      sl_mem  = '{default: 8'h00};
      repeat (4) @(negedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk(CFG, cmd_ready === 1'b1 && ss_n === 1'b1 && busy === 1'b0, "idle_after_rst",
            int'({cmd_ready, ss_n, busy}), 6);
      end
      // Directed: write A5 address, store 3C, read it back.
      send(2'b00, 8'hA5, 1'b0);
      send(2'b01, 8'h3C, 1'b0);
      send(2'b10, 8'hA5, 1'b0);
      send(2'b11, 8'h00, 1'b0);
      // Directed: all-ones and all-zeros bytes.
      send(2'b00, 8'h10, 1'b0);
      send(2'b01, 8'hFF, 1'b0);
      send(2'b00, 8'h11, 1'b0);
      send(2'b01, 8'h00, 1'b0);
      send(2'b10, 8'h10, 1'b0);
      send(2'b11, 8'h5A, 1'b0);
      send(2'b10, 8'h11, 1'b0);
      send(2'b11, 8'hC3, 1'b0);
      // Four queued ops with cmd_valid held throughout.
      send(2'b00, 8'h03, 1'b1);
      send(2'b01, 8'h96, 1'b1);
      send(2'b10, 8'h03, 1'b1);
      send(2'b11, 8'h00, 1'b0);
      // Random traffic on a small address window so reads hit written data.
      for (int i = 0; i < 40; i++) begin
        op   = 2'($urandom_range(0, 3));
        data = (op[0] == 1'b0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        hold = 1'($urandom_range(0, 1));
        send(op, data, hold);
        if (!hold && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      cmd_valid = 1'b0;
      drain();
      // Reset at frame cycle 6 of a write: frame dropped, nothing committed.
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_data  = 8'h5A;
      chk(CFG, cmd_ready === 1'b1, "abort_ready", int'(cmd_ready), 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1 chk(CFG, ss_n === 1'b0, "abort_mid_frame", int'(ss_n), 0);
      #1 rst = 1'b1;
      #1 chk(CFG, ss_n === 1'b1, "async_rst_ss_n", int'(ss_n), 1);
      chk(CFG, cmd_ready === 1'b0, "rst_ready_low", int'(cmd_ready), 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk(CFG, cmd_ready === 1'b1 && busy === 1'b0, "ready_after_abort", int'({cmd_ready, busy}), 2);
      send(2'b00, 8'h04, 1'b0);
      send(2'b01, 8'hE7, 1'b0);
      send(2'b10, 8'h04, 1'b0);
      send(2'b11, 8'h00, 1'b0);
      drain();
      done_flag = 1'b1;
    end

    // Monitor: behavioural slave, frame scoreboard and response scoreboard.
    always @(negedge clk) begin
      if (rst) begin
        chk(CFG, ss_n === 1'b1, "rst_ss_n", int'(ss_n), 1);
        chk(CFG, mosi === 1'b0, "rst_mosi", int'(mosi), 0);
        chk(CFG, busy === 1'b0, "rst_busy", int'(busy), 0);
        chk(CFG, rsp_valid === 1'b0, "rst_rsp_valid", int'(rsp_valid), 0);
        chk(CFG, rsp_data === 8'h00, "rst_rsp_data", int'(rsp_data), 0);
        fc = 0; hi_cnt = 0; had_frame = 1'b0; gap_trk = 1'b0;
        prev_rv = 1'b0; last_rsp = 8'h00; miso = 1'b0;
      end else begin
        chk(CFG, cmd_ready === ~busy, "ready_vs_busy", int'(cmd_ready), int'(~busy));
        if (ss_n === 1'b0) begin
          chk(CFG, busy === 1'b1, "busy_in_frame", int'(busy), 1);
          if (fc == 0) begin
            rd_frame = 1'b0;
            if (had_frame) chk(CFG, hi_cnt >= GAP, "gap_min", hi_cnt, GAP);
          end
          if (fc < 64) fbits[fc[5:0]] = mosi;
          if (fc >= 12) chk(CFG, mosi === 1'b0, "mosi_quiet", int'(mosi), 0);
          if (fc == 11) begin
            rd_frame = fbits[2] && fbits[3];
            sl_byte  = sl_mem[sl_rd];
          end
          if (rd_frame && fc >= 12 + TA && fc < 20 + TA) begin
            bi   = 19 + TA - fc;
            miso = sl_byte[bi[2:0]];
          end else begin
            miso = 1'b0;
          end
          fc++;
        end else begin
          miso = 1'b0;
          chk(CFG, mosi === 1'b0, "mosi_idle", int'(mosi), 0);
          if (fc > 0) begin
            chk(CFG, exp_frame_q.size() != 0, "frame_unexpected", fc, 0);
            if (exp_frame_q.size() != 0) begin
              ef      = exp_frame_q.pop_front();
              exp_len = (ef[9:8] == 2'b11) ? 20 + TA : 12;
              chk(CFG, fc == exp_len, "frame_len", fc, exp_len);
              chk(CFG, fbits[0] === ef[9] && fbits[1] === ef[9], "sel_bit",
                  int'({fbits[0], fbits[1]}), int'({ef[9], ef[9]}));
              got = '0;
              for (int k = 0; k < 10; k++) got = {got[8:0], fbits[6'(2 + k)]};
              chk(CFG, got === ef, "frame_bits", int'(got), int'(ef));
              seen_st = (fbits[1] == 1'b0) ? SLV_WRITE : (fbits[3] ? SLV_READ_DATA : SLV_READ_ADD);
              chk(CFG, seen_st == slv_expected(ef[9:8]), "slave_state", int'(seen_st),
                  int'(slv_expected(ef[9:8])));
              chk(CFG, rsp_valid === (ef[9:8] == 2'b11), "rsp_at_frame_end", int'(rsp_valid),
                  int'(ef[9:8] == 2'b11));
              if (fc >= 12) begin
                case (got[9:8])
                  2'b00:   sl_wr = got[7:0];
                  2'b01:   sl_mem[sl_wr] = got[7:0];
                  2'b10:   sl_rd = got[7:0];
                  default: ;
                endcase
              end
            end
            fc = 0; hi_cnt = 0; had_frame = 1'b1; gap_trk = 1'b1; gap_cnt = 0;
          end
          if (gap_trk) begin
            if (busy === 1'b1) begin
              gap_cnt++;
            end else begin
              chk(CFG, gap_cnt == GAP, "gap_len", gap_cnt, GAP);
              gap_trk = 1'b0;
            end
          end
          hi_cnt++;
        end
        if (rsp_valid === 1'b1) begin
          chk(CFG, !prev_rv, "rsp_single_pulse", int'(prev_rv), 0);
          chk(CFG, ss_n === 1'b1, "rsp_ss_high", int'(ss_n), 1);
          chk(CFG, exp_rsp_q.size() != 0, "rsp_unexpected", int'(rsp_data), 0);
          if (exp_rsp_q.size() != 0) begin
            er = exp_rsp_q.pop_front();
            chk(CFG, rsp_data === er, "rsp_data", int'(rsp_data), int'(er));
            last_rsp = er;
          end
        end else begin
          chk(CFG, rsp_data === last_rsp, "rsp_hold", int'(rsp_data), int'(last_rsp));
        end
        prev_rv = rsp_valid;
      end
    end
  end

  // Wait for both configurations, bounded, then report.
  initial begin
    int cyc = 0;
    while (!(cfg[0].done_flag && cfg[1].done_flag) && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    chk(-1, cfg[0].done_flag && cfg[1].done_flag, "global_timeout", cyc, 60000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Master-side sequencer for the SPI slave + RAM wrapper.
- Accepts one 10-bit command at a time from a requester over a valid/ready handshake.
- Frames each command on SS_n/MOSI so the slave FSM walks IDLE -> CHK_CMD -> WRITE/READ_ADD/READ_DATA -> IDLE.
- For read-data commands, captures the 8-bit MISO reply and returns it on a one-cycle response strobe.

Parameters:
- TA_CYC, 2, idle cycles between the last MOSI bit and the first MISO sample on read-data frames (1..7).
- GAP_CYC, 1, minimum SS_n-high cycles between frames (1..7).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  requester presents a command.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_op  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- cmd_data  in  8  address or data byte; ignored for op 11.
- rsp_valid  out  1  one-cycle pulse: rsp_data valid.
- rsp_data  out  8  byte captured from MISO.
- busy  out  1  frame or gap in progress.
- SS_n  out  1  slave select, active low, registered.
- MOSI  out  1  serial data to slave, registered.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (async, rst=1): SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, busy=0, state IDLE, counters 0. An in-flight command is dropped; no response is generated.
- cmd_ready = (state==IDLE) && !rst. This is combinational from state.
- Accept on cmd_valid && cmd_ready: latch shreg={cmd_op,cmd_data} (10 bits) and op; move to SEL.
- Frame cycle numbering: cycle 0 is the first clock with SS_n=0.
- FSM states: IDLE, SEL, SHIFT, TURN, CAPT, GAP.
  - IDLE: SS_n=1, MOSI=0.
  - SEL (2 cycles, frame cycles 0-1): SS_n=0, MOSI=op[1]. The bit is held two cycles so the slave's CHK_CMD sample sees it stable.
  - SHIFT (10 cycles, frame cycles 2-11): MOSI = shreg[9], shifted MSB-first, one bit per cycle (op[1], op[0], data[7..0]).
  - After SHIFT:
    - op!=11 -> GAP. SS_n rises at frame cycle 12; write frames are 12 cycles low.
    - op==11 -> TURN.
  - TURN (TA_CYC cycles): SS_n=0, MOSI=0.
  - CAPT (8 cycles): SS_n=0, MOSI=0. Sample MISO on each posedge and shift into rx MSB-first. After the 8th sample: rsp_data<=rx, rsp_valid=1 for exactly one cycle (the first cycle SS_n is high); go to GAP.
  - GAP (GAP_CYC cycles): SS_n=1, MOSI=0, then IDLE.
- Read-data frames hold SS_n low for 12+TA_CYC+8 cycles (22 at default).
- busy = (state!=IDLE).
- SS_n is never low in IDLE or GAP. It never glitches mid-frame; it changes only at frame start and frame end.
- One shared 4-bit down-counter serves SEL/SHIFT/TURN/CAPT/GAP and is loaded on each state entry.
- cmd_valid while busy is ignored; the requester must hold it until cmd_ready.
- Back-to-back commands are accepted in the IDLE cycle after GAP. Minimum command period = frame + GAP_CYC + 1.
- rsp_data holds its value until the next read-data completion.
- rsp_valid is never asserted for ops 00/01/10.
- Reset mid-frame: SS_n goes high immediately (async). After release the block is in IDLE with cmd_ready=1.

Decomposition:
- Shared package spi_pkg:
  - op enum: OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11.
  - Master state enum.
  - Constants: FRAME_BITS=10, SEL_CYC=2, RX_BITS=8.
  - The slave FSM encoding constants (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA) also move here for the bench and assertions.
- No sub-module needed. The shift register and counter stay inline.

Test Plan:
- Reset held then released with cmd_valid=0 -> SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0 throughout.
- Write-addr op=00, data=8'hA5 -> SS_n low exactly 12 cycles; MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1; slave state reaches WRITE; no rsp_valid.
- Write-data 8'h3C to addr 8'hA5, then read-addr 8'hA5, then read-data -> read frame SS_n low 22 cycles; MOSI select bit=1 for two cycles; rsp_valid single pulse with rsp_data=8'h3C.
- cmd_valid held continuously with 4 queued ops -> each accepted only when cmd_ready=1; SS_n high for >= GAP_CYC cycles between frames; order preserved.
- rst asserted at frame cycle 6 of a write -> SS_n=1 asynchronously in the same cycle; after release IDLE, cmd_ready=1, no rsp_valid; the next write completes normally.
- TA_CYC=1, GAP_CYC=3 build, read-data of stored 8'hFF then 8'h00 -> SS_n low 21 cycles; rsp_data=8'hFF then 8'h00; gap of 3 high cycles observed.
